// File: rtl/ddr_rd_tx_packetizer_pkg.sv
// Shared definitions for the DDR read-back TX packetizer: FSM encoding,
// default framing byte and a constant-friendly clog2.
package ddr_rd_tx_packetizer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WAIT_WORD,
    ST_SER,
    ST_CSUM,
    ST_DONE
  } state_t;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ddr_rd_tx_packetizer.sv
// Frames wide DDR read-back words into header-led packets and serializes them
// LSB byte first into the TX FIFO. Define TX_PKT_CSUM_EN to append an XOR checksum byte.
module ddr_rd_tx_packetizer
  import ddr_rd_tx_packetizer_pkg::*;
#(
  parameter int         DATA_W    = 128,
  parameter int         PKT_WORDS = 16,
  parameter logic [7:0] HDR_BYTE  = HDR_BYTE_DEFAULT
) (
  input  logic              Axi0Clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              fifo_afull,
  output logic              fifo_wr_en,
  output logic [7:0]        fifo_wdata,
  output logic              busy,
  output logic              pkt_done
);

  localparam int BYTES = DATA_W / 8;
  // A one-byte word still needs a 1-bit index so the register is never zero width.
  localparam int BIW = (clog2(BYTES) > 0) ? clog2(BYTES) : 1;
  localparam int WCW = clog2(PKT_WORDS) + 1;
  localparam logic [BIW-1:0] LAST_BYTE = BIW'(BYTES - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(PKT_WORDS - 1);

  state_t              r_state;
  logic [DATA_W-1:0]   r_shreg;
  logic [BIW-1:0]      r_byte_idx;
  logic [WCW-1:0]      r_word_cnt;
  logic                r_wr_en;
  logic [7:0]          r_wdata;
  logic                r_pkt_done;
`ifdef TX_PKT_CSUM_EN
  logic [7:0]          r_csum;
`endif

  logic w_last_byte;
  logic w_last_word;

  assign w_last_byte = (r_byte_idx == LAST_BYTE);
  assign w_last_word = (r_word_cnt == LAST_WORD);

  assign s_ready    = (r_state == ST_WAIT_WORD);
  assign busy       = (r_state != ST_IDLE);
  assign fifo_wr_en = r_wr_en;
  assign fifo_wdata = r_wdata;
  assign pkt_done   = r_pkt_done;

  // Every write stalls while the FIFO is almost full; a stalled cycle changes nothing.
  always_ff @(posedge Axi0Clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_byte_idx <= '0;
      r_word_cnt <= '0;
      r_wr_en    <= 1'b0;
      r_wdata    <= '0;
      r_pkt_done <= 1'b0;
`ifdef TX_PKT_CSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_wr_en    <= 1'b0;
      r_pkt_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
`ifdef TX_PKT_CSUM_EN
          r_csum <= '0;
`endif
          if (s_valid) r_state <= ST_HDR;
        end
        ST_HDR: begin
          if (!fifo_afull) begin
            r_wr_en <= 1'b1;
            r_wdata <= HDR_BYTE;
            r_state <= ST_WAIT_WORD;
          end
        end
        ST_WAIT_WORD: begin
          if (s_valid) begin
            r_shreg    <= s_data;
            r_byte_idx <= '0;
            r_state    <= ST_SER;
          end
        end
        ST_SER: begin
          if (!fifo_afull) begin
            r_wr_en <= 1'b1;
            r_wdata <= r_shreg[7:0];
            r_shreg <= r_shreg >> 8;
`ifdef TX_PKT_CSUM_EN
            r_csum  <= r_csum ^ r_shreg[7:0];
`endif
            if (w_last_byte) begin
              r_byte_idx <= '0;
              r_word_cnt <= r_word_cnt + 1'b1;
              if (w_last_word) begin
`ifdef TX_PKT_CSUM_EN
                r_state <= ST_CSUM;
`else
                r_state <= ST_DONE;
`endif
              end else begin
                r_state <= ST_WAIT_WORD;
              end
            end else begin
              r_byte_idx <= r_byte_idx + 1'b1;
            end
          end
        end
`ifdef TX_PKT_CSUM_EN
        ST_CSUM: begin
          if (!fifo_afull) begin
            r_wr_en <= 1'b1;
            r_wdata <= r_csum;
            r_state <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          r_pkt_done <= 1'b1;
          r_word_cnt <= '0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ddr_rd_tx_packetizer.md
Name: ddr_rd_tx_packetizer

Overview:
- Upstream stage of the UART TX data path, on the Axi0Clk domain.
- Accepts wide DDR read-back words on a valid/ready interface and frames them into packets.
- Serializes each word LSB-byte-first into byte writes for the asynchronous TX FIFO (write side), throttled by that FIFO's almost-full flag.
- Replaces the free-running test write FSM as the real producer of FIFO write data.

Parameters:
- DATA_W, 128, width of the input word; must be a multiple of 8; BYTES = DATA_W/8.
- PKT_WORDS, 16, input words per packet (>=1).
- HDR_BYTE, 8'hA5, framing byte written at the start of every packet.

Ports:
- Axi0Clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_W  read-back word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  block accepts s_data this cycle.
- fifo_afull  in  1  TX FIFO almost-full; the FIFO guarantees at least 2 free slots when asserted.
- fifo_wr_en  out  1  byte write strobe to TX FIFO.
- fifo_wdata  out  8  byte to TX FIFO.
- busy  out  1  high while a packet is in progress (state != IDLE).
- pkt_done  out  1  one-cycle pulse after the last byte of a packet is written.

Behaviour:
- Reset is synchronous, active-high. Reset state: FSM=IDLE; fifo_wr_en=0, fifo_wdata=0, pkt_done=0, busy=0; all counters and the shift register cleared.
- Reset mid-packet: the partial packet is abandoned and no further writes occur. The next packet starts with HDR_BYTE.
- fifo_wr_en, fifo_wdata and pkt_done are registered. s_ready is decoded combinationally from state only; it is high only in WAIT_WORD.
- A "write" means: fifo_wr_en=1 next cycle with the byte on fifo_wdata. A write is issued only in a cycle where fifo_afull=0. Otherwise the FSM holds with no state or data change.
- FSM states:
  - IDLE: if s_valid=1 -> HDR. s_data is not consumed here.
  - HDR: if !fifo_afull, write HDR_BYTE -> WAIT_WORD.
  - WAIT_WORD: on s_valid&&s_ready, load s_data into the shift register, byte_idx=0 -> SER. s_valid low: wait indefinitely with no writes.
  - SER: each cycle with !fifo_afull, write shreg[7:0], shift right 8, byte_idx++.
    - At byte_idx==BYTES-1: word_cnt++.
    - If word_cnt==PKT_WORDS-1, go to CSUM (feature enabled) or DONE; otherwise go to WAIT_WORD.
  - DONE: pkt_done=1 for one cycle, clear word_cnt -> IDLE.
- Packet length: 1 + PKT_WORDS*BYTES bytes (+1 with the optional feature).
- Throughput: 1 byte/cycle when the FIFO is not almost-full. A word boundary costs one WAIT_WORD cycle minimum.
- Counter widths: byte_idx is clog2(BYTES) bits; word_cnt is clog2(PKT_WORDS)+1 bits. Neither wraps inside a packet.
- Simultaneous fifo_afull rising in the same cycle as a write decision: the write still completes; the 2-slot guarantee covers it.

Optional Feature:
- Macro: TX_PKT_CSUM_EN.
- Defined:
  - An 8-bit XOR accumulator of all payload bytes (header excluded) is maintained, cleared in IDLE.
  - An extra CSUM state writes the accumulator byte when !fifo_afull, then goes to DONE.
- Undefined: no accumulator and no CSUM state; SER goes directly to DONE.

Decomposition:
- Shared package: FSM state encoding (IDLE, HDR, WAIT_WORD, SER, CSUM, DONE), the default HDR_BYTE constant, and a clog2 function.
- Single module; no sub-module is natural. The checksum is a few lines inline.

Test Plan:
- Bench parameters: DATA_W=32, PKT_WORDS=2.
- Send words 0x44332211, 0x88776655, afull=0 -> FIFO bytes A5 11 22 33 44 55 66 77 88; with TX_PKT_CSUM_EN, then 88. pkt_done pulses once, one cycle after the last write.
- Hold fifo_afull=1 for 5 cycles after byte 0x22 -> no writes during the hold. The stream resumes with 33 and the byte sequence is unchanged.
- Deassert s_valid for 10 cycles between words -> s_ready stays high, no writes, busy=1. The packet completes correctly once the second word arrives.
- Assert rst for 1 cycle after byte 0x33 -> outputs are 0 the next cycle. A new packet 0xDDCCBBAA, 0x11111111 produces A5 AA BB CC DD 11 11 11 11 (+ csum 0x00 when enabled).
- Two packets back-to-back with s_valid held high -> 18 bytes (20 with csum), each packet starts with A5, and pkt_done pulses exactly twice.
